// File: rtl/feeder_pkg.sv
// Shared encodings and limits for the feeder around the total network.
// Pure declarations: no latency, no backpressure.
package feeder_pkg;

   typedef enum logic [2:0] {
      S_WAIT_HI = 3'd0,
      S_ACK_HI  = 3'd1,
      S_WAIT_LO = 3'd2,
      S_SETTLE  = 3'd3,
      S_OUT     = 3'd4,
      S_OUT_END = 3'd5
   } state_t;

   localparam int SETTLE_MIN = 1;
   localparam int SETTLE_MAX = 15;
   localparam int CNT4_W     = 4;

endpackage

// File: rtl/feeder_rete_totale_settle_counter.sv
// settle_counter: loadable down-counter timing how long x7_x0 is held before sampling.
// Load takes effect on the next edge; dec saturates at zero; no backpressure.
module settle_counter
   import feeder_pkg::*;
(
   input  logic              clock,
   input  logic              reset_,
   input  logic              load,
   input  logic [CNT4_W-1:0] load_val,
   input  logic              dec,
   output logic              zero
);

   logic [CNT4_W-1:0] cnt_q;
   logic [CNT4_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/feeder_rete_totale.sv
// feeder_rete_totale: assembles two nibbles into x7_x0, samples z3_z0 SETTLE cycles after the low capture.
// Producer is held off (rfd_in=0) until the consumer finishes its four-phase handshake.
module feeder_rete_totale
   import feeder_pkg::*;
#(
   parameter int SETTLE = 3,
   parameter int CNT_W  = 8
) (
   input  logic             clock,
   input  logic             reset_,
   input  logic             dav_in_,
   input  logic [3:0]       nib_in,
   output logic             rfd_in,
   output logic [7:0]       x7_x0,
   input  logic [3:0]       z3_z0,
   output logic             dav_out_,
   output logic [3:0]       z_out,
   input  logic             rfd_out,
   output logic             busy,
   output logic [CNT_W-1:0] n_ops
);

   if ((SETTLE < SETTLE_MIN) || (SETTLE > SETTLE_MAX)) begin : g_settle_range
      $fatal(1, "feeder_rete_totale: SETTLE must lie in 1..15");
   end

   localparam logic [CNT4_W-1:0] SETTLE_LD = CNT4_W'(SETTLE - 1);

   state_t           state_q, state_d;
   logic             rfd_in_q, rfd_in_d;
   logic             dav_out_q, dav_out_d;
   logic [7:0]       x_q, x_d;
   logic [3:0]       z_q, z_d;
   logic [CNT_W-1:0] n_ops_q, n_ops_d;
   logic             cnt_load;
   logic             cnt_dec;
   logic             cnt_zero;

   settle_counter u_settle (
      .clock    (clock),
      .reset_   (reset_),
      .load     (cnt_load),
      .load_val (SETTLE_LD),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d   = state_q;
      rfd_in_d  = rfd_in_q;
      dav_out_d = dav_out_q;
      x_d       = x_q;
      z_d       = z_q;
      n_ops_d   = n_ops_q;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      case (state_q)
         S_WAIT_HI: begin
            if (!dav_in_ && rfd_in_q) begin
               x_d[7:4] = nib_in;
               rfd_in_d = 1'b0;
               state_d  = S_ACK_HI;
            end
         end
         S_ACK_HI: begin
            if (dav_in_) begin
               rfd_in_d = 1'b1;
               state_d  = S_WAIT_LO;
            end
         end
         S_WAIT_LO: begin
            if (!dav_in_ && rfd_in_q) begin
               x_d[3:0] = nib_in;
               rfd_in_d = 1'b0;
               cnt_load = 1'b1;
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else begin
               z_d       = z3_z0;
               dav_out_d = 1'b0;
               n_ops_d   = n_ops_q + CNT_W'(1);
               state_d   = S_OUT;
            end
         end
         S_OUT: begin
            // rfd_out falling is the consumer's acknowledge
            if (!rfd_out) begin
               dav_out_d = 1'b1;
               state_d   = S_OUT_END;
            end
         end
         S_OUT_END: begin
            if (rfd_out && dav_in_) begin
               rfd_in_d = 1'b1;
               state_d  = S_WAIT_HI;
            end
         end
         default: begin
            state_d  = S_WAIT_HI;
            rfd_in_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_) begin
      if (!reset_) begin
         state_q   <= S_WAIT_HI;
         rfd_in_q  <= 1'b1;
         dav_out_q <= 1'b1;
         x_q       <= '0;
         z_q       <= '0;
         n_ops_q   <= '0;
      end else begin
         state_q   <= state_d;
         rfd_in_q  <= rfd_in_d;
         dav_out_q <= dav_out_d;
         x_q       <= x_d;
         z_q       <= z_d;
         n_ops_q   <= n_ops_d;
      end
   end

   assign rfd_in   = rfd_in_q;
   assign dav_out_ = dav_out_q;
   assign x7_x0    = x_q;
   assign z_out    = z_q;
   assign n_ops    = n_ops_q;
   assign busy     = (state_q != S_WAIT_HI);

endmodule
